bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter.
// Masters are served round-robin on ties. The request is registered toward the slave,
// and each transaction completes with a one-cycle response: either the slave data or,
// after TIMEOUT_CYC cycles without an ack, an error.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (core)
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // master 1 (debug/DMA)
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // slave side
    output logic        s_req_o,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ack_i,
    // current owner, one-hot
    output logic [1:0]  grant_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic [7:0] cnt;
    logic       pick;

    // Winner of IDLE arbitration: the sole requester, or the one not served last on a tie
    always_comb begin
        pick = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            pick = ~last_owner;
        end
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= 8'd0;
            s_req_o    <= 1'b0;
            s_addr_o   <= 32'd0;
            s_we_o     <= 1'b0;
            s_wdata_o  <= 32'd0;
            m0_rdata_o <= 32'd0;
            m0_ack_o   <= 1'b0;
            m0_err_o   <= 1'b0;
            m1_rdata_o <= 32'd0;
            m1_ack_o   <= 1'b0;
            m1_err_o   <= 1'b0;
            grant_o    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        state     <= GRANT;
                        owner     <= pick;
                        cnt       <= 8'd0;
                        s_req_o   <= 1'b1;
                        s_addr_o  <= pick ? m1_addr_i  : m0_addr_i;
                        s_we_o    <= pick ? m1_we_i    : m0_we_i;
                        s_wdata_o <= pick ? m1_wdata_i : m0_wdata_i;
                        grant_o   <= pick ? 2'b10 : 2'b01;
                    end
                end
                GRANT: begin
                    if (s_ack_i || (cnt == TO_LAST)) begin
                        // Slave ack takes priority over a coincident timeout
                        state      <= RESP;
                        s_req_o    <= 1'b0;
                        last_owner <= owner;
                        if (owner) begin
                            m1_ack_o   <= 1'b1;
                            m1_err_o   <= ~s_ack_i;
                            m1_rdata_o <= s_ack_i ? s_rdata_i : 32'd0;
                        end else begin
                            m0_ack_o   <= 1'b1;
                            m0_err_o   <= ~s_ack_i;
                            m0_rdata_o <= s_ack_i ? s_rdata_i : 32'd0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    m0_ack_o <= 1'b0;
                    m0_err_o <= 1'b0;
                    m1_ack_o <= 1'b0;
                    m1_err_o <= 1'b0;
                    grant_o  <= 2'b00;
                end
                default: begin
                    state   <= IDLE;
                    s_req_o <= 1'b0;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level reference model.
module tb_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_req_o, s_we_o, s_ack_i;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [1:0]  grant_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: who was served last, and each master's last response data
    logic        ref_last;
    logic [31:0] ref_rdata [2];

    bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i),
        .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i),
        .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    // One clock: inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one transaction acting as both masters and the slave; returns what was observed.
    // ack_at: GRANT cycle (1-based) in which the slave acks, 0 = never.
    task automatic do_txn(
        input  logic r0, input logic r1,
        input  logic [31:0] a0, input logic [31:0] a1,
        input  logic w0, input logic w1,
        input  logic [31:0] d0, input logic [31:0] d1,
        input  int ack_at, input logic [31:0] sdata, input bit drop,
        output int lat, output int nreq,
        output logic [1:0] gnt_g, output logic [1:0] gnt_r,
        output logic [31:0] saddr, output logic swe, output logic [31:0] swd,
        output logic [3:0] resp, output bit hung);
        m0_req_i = r0; m0_addr_i = a0; m0_we_i = w0; m0_wdata_i = d0;
        m1_req_i = r1; m1_addr_i = a1; m1_we_i = w1; m1_wdata_i = d1;
        s_rdata_i = sdata; s_ack_i = 1'b0;
        lat = 0; nreq = 0; gnt_g = 2'b00; gnt_r = 2'b00;
        saddr = 32'd0; swe = 1'b0; swd = 32'd0; resp = 4'd0; hung = 1'b1;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            tick();
            s_ack_i = 1'b0;
            if (m0_ack_o || m1_ack_o) begin
                lat   = cyc;
                gnt_r = grant_o;
                resp  = {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};
                hung  = 1'b0;
                break;
            end
            if (s_req_o) begin
                nreq++;
                gnt_g = grant_o; saddr = s_addr_o; swe = s_we_o; swd = s_wdata_o;
                if (nreq == ack_at) s_ack_i = 1'b1;
                if (drop) begin
                    m0_req_i = 1'b0;
                    m1_req_i = 1'b0;
                end
            end
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_ack_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
        m0_addr_i = 0; m1_addr_i = 0; m0_wdata_i = 0; m1_wdata_i = 0;
        s_ack_i = 0; s_rdata_i = 0;
        tick(); tick();
        rst = 1'b0;
        ref_last = 1'b1;
        ref_rdata[0] = 32'd0;
        ref_rdata[1] = 32'd0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({s_req_o, s_we_o, grant_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0",
                     {s_req_o, s_we_o, grant_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        n_tests++;
        if ({s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h %h want 0", s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o);
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        int lat, nreq; logic [1:0] gg, gr; logic [31:0] sa, swd; logic swe; logic [3:0] rs; bit hung;
        do_txn(1, 0, 32'h1000_0004, 0, 0, 0, 0, 0, 2, 32'hDEAD_BEEF, 0,
               lat, nreq, gg, gr, sa, swe, swd, rs, hung);
        n_tests++;
        if (lat !== 3 || nreq !== 2 || hung) begin
            n_fail++; $display("FAIL single_timing got lat=%0d sreq=%0d hung=%0d want lat=3 sreq=2", lat, nreq, hung);
        end
        n_tests++;
        if (sa !== 32'h1000_0004 || swe !== 1'b0 || gg !== 2'b01) begin
            n_fail++; $display("FAIL single_bus got addr=%h we=%b gnt=%b want 10000004 0 01", sa, swe, gg);
        end
        n_tests++;
        if (rs !== 4'b0001 || m0_rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_resp got resp=%b rdata=%h want 0001 deadbeef", rs, m0_rdata_o);
        end
        ref_last = 1'b0; ref_rdata[0] = 32'hDEAD_BEEF;
        tick();
        n_tests++;
        if ({m0_ack_o, m1_ack_o, grant_o, s_req_o} !== 5'd0 || m0_rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_after got ctl=%b rdata=%h want 0 deadbeef",
                               {m0_ack_o, m1_ack_o, grant_o, s_req_o}, m0_rdata_o);
        end
    endtask

    task automatic test_tie_round_robin();
        int lat, nreq; logic [1:0] gg, gr; logic [31:0] sa, swd; logic swe; logic [3:0] rs; bit hung;
        logic [1:0] want;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            do_txn(1, 1, 32'h100 + 32'(i), 32'h200 + 32'(i), 0, 0, 0, 0, 2, 32'hA000_0000 + 32'(i), 0,
                   lat, nreq, gg, gr, sa, swe, swd, rs, hung);
            n_tests++;
            if (gg !== want || gr !== want || lat !== 3) begin
                n_fail++; $display("FAIL tie_%0d got gnt=%b/%b lat=%0d want %b lat=3", i, gg, gr, lat, want);
            end
            n_tests++;
            if (sa !== (want[1] ? 32'h200 + 32'(i) : 32'h100 + 32'(i))) begin
                n_fail++; $display("FAIL tie_addr_%0d got %h", i, sa);
            end
            ref_last = want[1];
            ref_rdata[want[1]] = 32'hA000_0000 + 32'(i);
            tick();
        end
    endtask

    task automatic test_timeout_write();
        int lat, nreq; logic [1:0] gg, gr; logic [31:0] sa, swd; logic swe; logic [3:0] rs; bit hung;
        do_txn(0, 1, 0, 32'h3000_0000, 0, 1, 0, 32'h5A5A_5A5A, 0, 32'h1234_5678, 0,
               lat, nreq, gg, gr, sa, swe, swd, rs, hung);
        n_tests++;
        if (nreq !== TO || lat !== TO + 1) begin
            n_fail++; $display("FAIL timeout_len got sreq=%0d lat=%0d want %0d %0d", nreq, lat, TO, TO + 1);
        end
        n_tests++;
        if (swe !== 1'b1 || sa !== 32'h3000_0000 || swd !== 32'h5A5A_5A5A) begin
            n_fail++; $display("FAIL timeout_bus got we=%b addr=%h wd=%h", swe, sa, swd);
        end
        n_tests++;
        if (rs !== 4'b1100 || m1_rdata_o !== 32'd0) begin
            n_fail++; $display("FAIL timeout_resp got resp=%b rdata=%h want 1100 0", rs, m1_rdata_o);
        end
        ref_last = 1'b1; ref_rdata[1] = 32'd0;
        tick();
    endtask

    task automatic test_ack_last_cycle();
        int lat, nreq; logic [1:0] gg, gr; logic [31:0] sa, swd; logic swe; logic [3:0] rs; bit hung;
        do_txn(1, 0, 32'h44, 0, 0, 0, 0, 0, TO, 32'hCAFE_F00D, 0,
               lat, nreq, gg, gr, sa, swe, swd, rs, hung);
        n_tests++;
        if (rs !== 4'b0001 || m0_rdata_o !== 32'hCAFE_F00D || lat !== TO + 1) begin
            n_fail++; $display("FAIL ack_last got resp=%b rdata=%h lat=%0d want 0001 cafef00d %0d",
                               rs, m0_rdata_o, lat, TO + 1);
        end
        ref_last = 1'b0; ref_rdata[0] = 32'hCAFE_F00D;
        tick();
    endtask

    task automatic test_stray_ack();
        int acks = 0;
        int lat, nreq; logic [1:0] gg, gr; logic [31:0] sa, swd; logic swe; logic [3:0] rs; bit hung;
        s_rdata_i = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1'b1;
            tick();
            if (m0_ack_o || m1_ack_o || s_req_o || grant_o != 2'b00) acks++;
        end
        s_ack_i = 1'b0;
        tick();
        if (m0_ack_o || m1_ack_o) acks++;
        n_tests++;
        if (acks !== 0 || m0_rdata_o !== ref_rdata[0]) begin
            n_fail++; $display("FAIL stray_ack got events=%0d rdata=%h want 0 %h", acks, m0_rdata_o, ref_rdata[0]);
        end
        do_txn(0, 1, 0, 32'h88, 0, 0, 0, 0, 1, 32'h0000_0777, 0,
               lat, nreq, gg, gr, sa, swe, swd, rs, hung);
        n_tests++;
        if (rs !== 4'b0100 || lat !== 2 || m1_rdata_o !== 32'h777) begin
            n_fail++; $display("FAIL stray_then_txn got resp=%b lat=%0d rdata=%h want 0100 2 777", rs, lat, m1_rdata_o);
        end
        ref_last = 1'b1; ref_rdata[1] = 32'h777;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        int acks = 0;
        int lat, nreq; logic [1:0] gg, gr; logic [31:0] sa, swd; logic swe; logic [3:0] rs; bit hung;
        m0_req_i = 1'b1; m0_addr_i = 32'h55; m0_we_i = 1'b1; m0_wdata_i = 32'h66;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({s_req_o, s_we_o, grant_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 8'd0 ||
            {s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o} !== 128'd0) begin
            n_fail++; $display("FAIL rst_mid got ctl=%b addr=%h want 0",
                               {s_req_o, s_we_o, grant_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, s_addr_o);
        end
        m0_req_i = 1'b0;
        tick();
        rst = 1'b0;
        ref_last = 1'b1; ref_rdata[0] = 32'd0; ref_rdata[1] = 32'd0;
        for (int i = 0; i < TO + 4; i++) begin
            tick();
            if (m0_ack_o || m0_err_o || m1_ack_o || s_req_o) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL rst_no_ack got %0d events want 0", acks);
        end
        do_txn(1, 1, 32'h10, 32'h20, 0, 0, 0, 0, 3, 32'h0BAD_CAFE, 0,
               lat, nreq, gg, gr, sa, swe, swd, rs, hung);
        n_tests++;
        if (gg !== 2'b01 || rs !== 4'b0001 || m0_rdata_o !== 32'h0BAD_CAFE || lat !== 4) begin
            n_fail++; $display("FAIL rst_then_tie got gnt=%b resp=%b rdata=%h lat=%0d want 01 0001 0badcafe 4",
                               gg, rs, m0_rdata_o, lat);
        end
        ref_last = 1'b0; ref_rdata[0] = 32'h0BAD_CAFE;
        tick();
    endtask

    task automatic test_random();
        int lat, nreq; logic [1:0] gg, gr; logic [31:0] sa, swd; logic swe; logic [3:0] rs; bit hung;
        logic r0, r1, w0, w1, own, terr; logic [31:0] a0, a1, d0, d1, sd, want_rd;
        int ack_at, len; bit drop; logic [1:0] want_g; logic [3:0] want_rs;
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom; sd = $urandom;
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 4));
            drop = ($urandom_range(0, 3) == 0);
            // Model: round-robin on tie, otherwise the single requester; timeout after TO cycles
            own     = (r0 && r1) ? ~ref_last : r1;
            terr    = (ack_at == 0) || (ack_at > TO);
            len     = terr ? TO : ack_at;
            want_g  = own ? 2'b10 : 2'b01;
            want_rs = own ? {terr, 1'b1, 2'b00} : {2'b00, terr, 1'b1};
            want_rd = terr ? 32'd0 : sd;
            do_txn(r0, r1, a0, a1, w0, w1, d0, d1, ack_at, sd, drop,
                   lat, nreq, gg, gr, sa, swe, swd, rs, hung);
            n_tests++;
            if (hung || lat !== len + 1 || nreq !== len) begin
                n_fail++; $display("FAIL rand_%0d_timing got lat=%0d sreq=%0d hung=%0d want %0d %0d",
                                   i, lat, nreq, hung, len + 1, len);
            end
            n_tests++;
            if (gg !== want_g || gr !== want_g || rs !== want_rs) begin
                n_fail++; $display("FAIL rand_%0d_owner got gnt=%b/%b resp=%b want %b %b", i, gg, gr, rs, want_g, want_rs);
            end
            n_tests++;
            if (sa !== (own ? a1 : a0) || swe !== (own ? w1 : w0) || swd !== (own ? d1 : d0)) begin
                n_fail++; $display("FAIL rand_%0d_bus got %h %b %h", i, sa, swe, swd);
            end
            ref_last = own;
            ref_rdata[own] = want_rd;
            n_tests++;
            if (m0_rdata_o !== ref_rdata[0] || m1_rdata_o !== ref_rdata[1]) begin
                n_fail++; $display("FAIL rand_%0d_rdata got %h %h want %h %h",
                                   i, m0_rdata_o, m1_rdata_o, ref_rdata[0], ref_rdata[1]);
            end
            tick();
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_single_read();
        test_tie_round_robin();
        test_timeout_write();
        test_ack_last_cycle();
        test_stray_ack();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
